// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package sevenseg_pkg;

    localparam int NDIG = 4;

    localparam logic [6:0]  SEG_OFF  = 7'h7F;
    localparam logic [6:0]  SEG_DASH = 7'b0111111;
    localparam logic [15:0] MAX_DEC  = 16'd9999;

    // Entry n is the glyph for hex digit n (index 15 is listed first).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        return SEG_LUT[digit];
    endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Display value/control inputs and the multiplexed panel outputs.
// Master drives the value and controls; slave (the scanner) drives the panel.
interface sevenseg_if;
    logic [15:0] value;
    logic        dec_mode;
    logic        lz_en;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        ovf;
    logic        busy;

    modport master (
        output value, dec_mode, lz_en, blank, dp,
        input  seg_n, dp_n, an_n, ovf, busy
    );

    modport slave (
        input  value, dec_mode, lz_en, blank, dp,
        output seg_n, dp_n, an_n, ovf, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to BCD in 17 busy cycles.
// done pulses on the last busy cycle; a start while busy restarts the conversion.
module bin2bcd_seq
    import sevenseg_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] sh_q, sh_d;
    logic [19:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [19:0] adj;
    logic [35:0] shifted;

    always_comb begin
        adj = acc_q;
        for (int k = 0; k < 5; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
        end
        shifted = {adj, sh_q} << 1;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            sh_d   = bin;
            acc_d  = '0;
            ovf_d  = (bin > MAX_DEC);
        end else if (busy_q) begin
            // Sixteen shift steps, then one cycle to hand the result over.
            if (cnt_q == 5'd16) begin
                busy_d = 1'b0;
            end else begin
                {acc_d, sh_d} = shifted;
                cnt_d         = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == 5'd16) && !start;
    assign bcd  = acc_q[15:0];
    assign ovf  = ovf_q;

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment scanner, hex or decimal, one digit per SCAN_DIV cycles.
// Panel outputs are registered and change only on a scan tick; no backpressure.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       clr_n,
    sevenseg_if.slave  io
);

    localparam int             PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [1:0]              slot_q, slot_d;
    logic                    started_q, started_d;
    logic [15:0]             snap_q, snap_d;
    logic                    hex_ld_q, hex_ld_d;
    logic [NDIG-1:0][3:0]    digit_q, digit_d;
    logic                    ovf_q, ovf_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dpn_q, dpn_d;

    logic                    tick, sample, lead_zero, slot_off;
    logic                    conv_start, conv_busy, conv_done, conv_ovf;
    logic [15:0]             conv_bcd;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .clr_n (clr_n),
        .start (conv_start),
        .bin   (io.value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        // slot_q names the digit the next tick will show.
        slot_d    = tick ? slot_q + 2'd1 : slot_q;
        sample    = !started_q || (tick && slot_q == 2'(NDIG - 1));
        started_d = 1'b1;
        snap_d    = sample ? io.value : snap_q;
        hex_ld_d  = sample && !io.dec_mode;
        conv_start = sample && io.dec_mode;

        digit_d = digit_q;
        ovf_d   = ovf_q;
        if (hex_ld_q) begin
            digit_d = snap_q;
            ovf_d   = 1'b0;
        end else if (conv_done) begin
            digit_d = conv_bcd;
            ovf_d   = conv_ovf;
        end

        lead_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= int'(slot_q) && digit_q[i] != 4'd0) lead_zero = 1'b0;
        end
        slot_off = io.blank[slot_q] ||
                   (io.lz_en && !ovf_q && slot_q != 2'd0 && lead_zero);

        an_d  = an_q;
        seg_d = seg_q;
        dpn_d = dpn_q;
        if (tick) begin
            if (slot_off) begin
                an_d  = 4'hF;
                seg_d = SEG_OFF;
                dpn_d = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << slot_q);
                seg_d = ovf_q ? SEG_DASH : seg_of(digit_q[slot_q]);
                dpn_d = ~io.dp[slot_q];
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc_q   <= '0;
            slot_q    <= '0;
            started_q <= 1'b0;
            snap_q    <= '0;
            hex_ld_q  <= 1'b0;
            digit_q   <= '0;
            ovf_q     <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= SEG_OFF;
            dpn_q     <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            slot_q    <= slot_d;
            started_q <= started_d;
            snap_q    <= snap_d;
            hex_ld_q  <= hex_ld_d;
            digit_q   <= digit_d;
            ovf_q     <= ovf_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dpn_q     <= dpn_d;
        end
    end

    assign io.an_n  = an_q;
    assign io.seg_n = seg_q;
    assign io.dp_n  = dpn_q;
    assign io.ovf   = ovf_q;
    assign io.busy  = conv_busy;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan at SCAN_DIV=32: table vectors, corner sequences and
// random frames against an arithmetic display model.
module tb_sevenseg_scan;

    localparam int DIV   = 32;
    localparam int FRAME = 4 * DIV;

    typedef struct {
        logic [15:0]      value;
        logic             dec;
        logic             lz;
        logic [3:0]       blank;
        logic [3:0]       dp;
        logic [3:0][6:0]  seg;
        logic [3:0]       on;
        logic [3:0]       dpn;
        logic             ovf;
        string            nm;
    } vec_t;

    logic clk;
    logic clr_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    sevenseg_if io ();

    sevenseg_scan #(.SCAN_DIV(DIV)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [6:0] hex_seg(input int d);
        case (d)
            0:  return 7'b1000000;  1:  return 7'b1111001;
            2:  return 7'b0100100;  3:  return 7'b0110000;
            4:  return 7'b0011001;  5:  return 7'b0010010;
            6:  return 7'b0000010;  7:  return 7'b1111000;
            8:  return 7'b0000000;  9:  return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic vec_t model(input logic [15:0] v, input logic d, input logic lz,
                                   input logic [3:0] bl, input logic [3:0] dpi);
        vec_t r;
        int   dig[4];
        int   msd;
        logic ov;
        logic off;
        r.value = v; r.dec = d; r.lz = lz; r.blank = bl; r.dp = dpi; r.nm = "rand";
        ov = d && (int'(v) > 9999);
        for (int i = 0; i < 4; i++)
            dig[i] = d ? (int'(v) / (10 ** i)) % 10 : (int'(v) >> (4 * i)) % 16;
        msd = 0;
        for (int i = 0; i < 4; i++) if (dig[i] != 0) msd = i;
        for (int i = 0; i < 4; i++) begin
            off       = bl[i] || (lz && !ov && i > msd);
            r.on[i]   = !off;
            r.seg[i]  = off ? 7'h7F : (ov ? 7'b0111111 : hex_seg(dig[i]));
            r.dpn[i]  = ~dpi[i];
        end
        r.ovf = ov;
        return r;
    endfunction

    // Apply a vector, wait for the next frame sample, then check all four slots.
    task automatic run_frame(input vec_t v);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        io.value = v.value; io.dec_mode = v.dec; io.lz_en = v.lz;
        io.blank = v.blank; io.dp = v.dp;
        do step(); while (cyc % FRAME != 0);
        for (int s = 0; s < 4; s++) begin
            repeat (DIV) step();
            exp_an  = v.on[s] ? ~(4'b0001 << s) : 4'hF;
            exp_seg = v.on[s] ? v.seg[s] : 7'h7F;
            exp_dp  = v.on[s] ? v.dpn[s] : 1'b1;
            check($sformatf("%s v=%h slot%0d {an,seg,dp}", v.nm, v.value, s),
                  {io.an_n, io.seg_n, io.dp_n}, {exp_an, exp_seg, exp_dp});
        end
        check($sformatf("%s v=%h ovf", v.nm, v.value), io.ovf, v.ovf);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " an_n"},  io.an_n,  4'hF);
        check({nm, " seg_n"}, io.seg_n, 7'h7F);
        check({nm, " dp_n"},  io.dp_n,  1'b1);
        check({nm, " ovf"},   io.ovf,   1'b0);
        check({nm, " busy"},  io.busy,  1'b0);
    endtask

    // After release with decimal 'value': 17 busy cycles, then slot 0 on the first tick.
    task automatic after_release(input string nm, input logic [6:0] exp_seg0);
        int  busy_cnt;
        bit  all_off;
        busy_cnt = 0;
        all_off  = 1;
        for (int k = 1; k <= DIV; k++) begin
            step();
            if (io.busy === 1'b1) busy_cnt++;
            if (k < DIV && io.an_n !== 4'hF) all_off = 0;
            if (k == 1) check({nm, " busy after sample"}, io.busy, 1'b1);
            if (k == 18) check({nm, " busy fallen"}, io.busy, 1'b0);
        end
        check({nm, " an_n dark before first tick"}, all_off, 1'b1);
        check({nm, " busy cycles"}, busy_cnt, 17);
        check({nm, " first tick {an,seg}"}, {io.an_n, io.seg_n}, {4'b1110, exp_seg0});
        check({nm, " ovf"}, io.ovf, 1'b0);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;

        tbl[0] = '{16'hBEEF, 1'b0, 1'b0, 4'b0000, 4'b0100,
                   {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110},
                   4'b1111, 4'b1011, 1'b0, "hex_beef"};
        tbl[1] = '{16'd1234, 1'b1, 1'b0, 4'b0000, 4'b0000,
                   {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                   4'b1111, 4'b1111, 1'b0, "dec_1234"};
        tbl[2] = '{16'd7, 1'b1, 1'b1, 4'b0000, 4'b0000,
                   {7'h7F, 7'h7F, 7'h7F, 7'b1111000},
                   4'b0001, 4'b1111, 1'b0, "dec_7_lz"};
        tbl[3] = '{16'd0, 1'b1, 1'b1, 4'b0000, 4'b0000,
                   {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
                   4'b0001, 4'b1111, 1'b0, "dec_0_lz"};
        tbl[4] = '{16'd10000, 1'b1, 1'b0, 4'b0000, 4'b0000,
                   {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111},
                   4'b1111, 4'b1111, 1'b1, "dec_ovf"};
        tbl[5] = '{16'd10000, 1'b1, 1'b1, 4'b0000, 4'b0000,
                   {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111},
                   4'b1111, 4'b1111, 1'b1, "dec_ovf_lz"};
        tbl[6] = '{16'h00A0, 1'b0, 1'b1, 4'b0001, 4'b1111,
                   {7'h7F, 7'h7F, 7'b0001000, 7'h7F},
                   4'b0010, 4'b1101, 1'b0, "hex_blank_lz"};

        // Reset held low, then release with decimal 1234 pending.
        io.value = 16'd1234; io.dec_mode = 1'b1; io.lz_en = 1'b0;
        io.blank = 4'b0000;  io.dp = 4'b0000;
        clr_n = 1'b1;
        #2 clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;
        after_release("release", 7'b0011001);

        for (int i = 0; i < 7; i++) run_frame(tbl[i]);

        // Value change mid-frame must not disturb the frame already sampled.
        io.value = 16'h1111; io.dec_mode = 1'b0; io.lz_en = 1'b0;
        io.blank = 4'b0000;  io.dp = 4'b0000;
        do step(); while (cyc % FRAME != 0);
        repeat (DIV) step();
        check("snap slot0", {io.an_n, io.seg_n}, {4'b1110, 7'b1111001});
        repeat (8) step();
        io.value = 16'h2222;
        repeat (DIV - 8) step();
        check("snap slot1", {io.an_n, io.seg_n}, {4'b1101, 7'b1111001});
        repeat (DIV) step();
        check("snap slot2", {io.an_n, io.seg_n}, {4'b1011, 7'b1111001});
        repeat (DIV) step();
        check("snap slot3", {io.an_n, io.seg_n}, {4'b0111, 7'b1111001});
        repeat (DIV) step();
        check("snap next slot0", {io.an_n, io.seg_n}, {4'b1110, 7'b0100100});

        // Reset asserted in the eighth busy cycle of a conversion.
        io.value = 16'd4321; io.dec_mode = 1'b1;
        do step(); while (cyc % FRAME != 0);
        check("midconv busy cycle1", io.busy, 1'b1);
        repeat (7) step();
        check("midconv busy cycle8", io.busy, 1'b1);
        clr_n = 1'b0;
        #1;
        check_reset_outputs("midconv reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;
        after_release("midconv release", 7'b1111001);

        for (int n = 0; n < 30; n++) begin
            logic        d;
            logic [15:0] v;
            logic [3:0]  bl;
            d  = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 300))
                                             : 16'($urandom_range(0, 65535));
            bl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rv = model(v, d, 1'($urandom_range(0, 1)), bl, 4'($urandom_range(0, 15)));
            run_frame(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
